matbi_watch_time_counter: RTL and testbench
===========================================

Name: matbi_watch_time_counter

Overview:
- Time-of-day counter that sits directly downstream of the one-second / button tick generator.
- Consumes the generator's one-second tick to advance seconds, minutes and hours.
- Consumes the generator's button tick as the auto-repeat rate for the +1 set button.
- Owns the run/set mode state machine and drives the registered time fields that the display stage reads.

Parameters:
- P_HOUR_MAX, 24: hour modulus; hour wraps from P_HOUR_MAX-1 to 0. Legal range 2..32.
- P_SEC_MAX, 60: modulus of both the seconds field and the minutes field.

Ports:
- clk  in  1  system clock; all state is on rising edges.
- reset  in  1  asynchronous, active-low reset (asserted at 0). Assertion clears all state immediately; release is sampled on clk.
- i_run_en  in  1  counting enable; only gates i_one_sec_tick.
- i_one_sec_tick  in  1  one-cycle pulse, once per second, from the tick generator.
- i_btn_tick  in  1  one-cycle auto-repeat pulse from the tick generator.
- i_btn_mode  in  1  raw mode button, asynchronous, active-high.
- i_btn_plus  in  1  raw +1 button, asynchronous, active-high.
- o_sec  out  6  seconds, 0..P_SEC_MAX-1.
- o_min  out  6  minutes, 0..P_SEC_MAX-1.
- o_hour  out  5  hours, 0..P_HOUR_MAX-1.
- o_mode  out  2  0=RUN, 1=SET_SEC, 2=SET_MIN, 3=SET_HOUR.
- o_day_tick  out  1  one-cycle pulse when the hour field wraps to 0 in RUN.

Behaviour:
- Reset values: o_sec=0, o_min=0, o_hour=0, o_mode=RUN, o_day_tick=0. All synchronizer and edge registers are cleared to 0.
- Button conditioning, applied to each button:
  - 3-stage shift: s1<=raw, s2<=s1, s3<=s2.
  - rise = s2 & ~s3; held = s2.
  - A raw level that is stable before rising edge N produces rise during the cycle after edge N+1. The resulting state change is visible after edge N+2.
  - Press-to-update latency is therefore 3 clocks.
- Mode FSM:
  - A mode rise steps the mode RUN -> SET_SEC -> SET_MIN -> SET_HOUR -> RUN.
  - One step per rise, regardless of how long the button is held.
- RUN mode, when i_one_sec_tick & i_run_en:
  - sec increments.
  - When sec==P_SEC_MAX-1: sec becomes 0 and min increments.
  - When min==P_SEC_MAX-1 as well: min becomes 0 and hour increments.
  - When hour==P_HOUR_MAX-1 as well: hour becomes 0 and o_day_tick is 1 for exactly the next cycle.
  - All carries resolve in the same clock; fields never show an intermediate value.
- RUN mode, plus button: plus rise and i_btn_tick are ignored.
- SET modes, time counting: i_one_sec_tick is ignored and the time is frozen. o_day_tick is never asserted.
- SET modes, plus button:
  - A plus rise increments the selected field by 1.
  - While plus is held (held=1) and rise=0, each i_btn_tick increments the selected field by 1 (auto-repeat).
  - Rise and i_btn_tick in the same cycle produce a single increment.
  - The selected field wraps modulo its own limit with no carry into other fields (59->0 on sec/min, P_HOUR_MAX-1 -> 0 on hour).
- Simultaneous events:
  - Mode rise and plus rise in the same cycle: the mode step wins and the plus is discarded for that cycle. Auto-repeat resumes on later i_btn_tick while plus is held, applied to the new mode's field.
  - Mode rise from SET_HOUR to RUN while i_one_sec_tick is high: no count in that cycle (the old mode governs). Counting starts on the next tick.
- i_run_en=0: one-second ticks are dropped, not queued. Buttons and the mode FSM still operate.
- Reset asserted mid-operation: all outputs return to their reset values asynchronously, and any pending edge is lost. After release, a button already held does not generate a rise until it is released and pressed again.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Widths: fields are compared against limit-1. Field values outside their range are unreachable, and the verification engineer shall add an assertion for this.

Test Plan:
- Reset is 0 for 5 cycles, then 1; no stimulus for 20 cycles -> o_sec/o_min/o_hour=0, o_mode=0, o_day_tick=0 throughout.
- RUN, state preloaded via set mode to 23:59:58; two i_one_sec_tick pulses -> 23:59:59, then 00:00:00 with o_day_tick high for exactly 1 cycle following the second tick.
- i_btn_mode pulsed 2 times -> o_mode=2. i_btn_plus raised for one press -> o_min 0->1 exactly 3 clocks after the raw rise. Drive 59 more presses -> o_min=0, o_hour unchanged.
- SET_HOUR, i_btn_plus held high for the duration of 30 i_btn_tick pulses -> o_hour advances 1 (edge) + 30 = 31 increments from 0, giving 31 mod 24 = 7. i_one_sec_tick pulses during this window leave o_sec unchanged.
- Mode rise and plus rise in the same cycle from SET_SEC -> o_mode=2, o_sec and o_min unchanged. i_run_en=0 in RUN with 10 ticks -> time unchanged.
- Reset pulled low mid-count at 00:12:34 while plus is held -> outputs 0 before the next clk edge. After release with plus still held -> no increment until plus is released and re-pressed.

Source files
------------

// File: rtl/matbi_watch_time_counter.sv
// rtl/matbi_watch_time_counter.sv - time-of-day counter with run/set mode FSM and +1 auto-repeat
module matbi_watch_time_counter #(
  parameter int P_HOUR_MAX = 24,
  parameter int P_SEC_MAX  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_run_en,
  input  logic       i_one_sec_tick,
  input  logic       i_btn_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_plus,
  output logic [5:0] o_sec,
  output logic [5:0] o_min,
  output logic [4:0] o_hour,
  output logic [1:0] o_mode,
  output logic       o_day_tick
);

  localparam logic [5:0] SEC_LAST  = 6'(P_SEC_MAX - 1);
  localparam logic [4:0] HOUR_LAST = 5'(P_HOUR_MAX - 1);

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_SEC  = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_HOUR = 2'd3
  } mode_e;

  // [0]=s1, [1]=s2, [2]=s3 of each button's synchronizer
  logic [2:0] mode_sync;
  logic [2:0] plus_sync;
  // Marks when s2 carries a real post-reset sample rather than its reset value
  logic [1:0] sync_valid;
  // A button only becomes usable after it has been seen released since reset,
  // so a button held through reset can neither rise nor auto-repeat.
  logic       mode_arm;
  logic       plus_arm;

  logic       mode_rise;
  logic       plus_rise;
  logic       plus_held;

  mode_e      mode_q;
  mode_e      mode_d;

  logic       run_mode;
  logic       sel_sec;
  logic       sel_min;
  logic       sel_hour;

  logic [5:0] sec_q;
  logic [5:0] min_q;
  logic [4:0] hour_q;
  logic       day_tick_q;

  logic       count_en;
  logic       plus_inc;
  logic       sec_last;
  logic       min_last;
  logic       hour_last;

  // Button synchronizers, edge history and release arming
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_sync  <= 3'b000;
      plus_sync  <= 3'b000;
      sync_valid <= 2'b00;
      mode_arm   <= 1'b0;
      plus_arm   <= 1'b0;
    end else begin
      mode_sync  <= {mode_sync[1:0], i_btn_mode};
      plus_sync  <= {plus_sync[1:0], i_btn_plus};
      sync_valid <= {sync_valid[0], 1'b1};
      mode_arm   <= mode_arm | (sync_valid[1] & ~mode_sync[1]);
      plus_arm   <= plus_arm | (sync_valid[1] & ~plus_sync[1]);
    end
  end

  assign mode_rise = mode_sync[1] & ~mode_sync[2] & mode_arm;
  assign plus_rise = plus_sync[1] & ~plus_sync[2] & plus_arm;
  assign plus_held = plus_sync[1] & plus_arm;

  // Mode state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Mode next-state: one step per mode rise, cycling back to RUN
  always_comb begin
    mode_d = mode_q;
    if (mode_rise) begin
      case (mode_q)
        MODE_RUN:      mode_d = MODE_SET_SEC;
        MODE_SET_SEC:  mode_d = MODE_SET_MIN;
        MODE_SET_MIN:  mode_d = MODE_SET_HOUR;
        MODE_SET_HOUR: mode_d = MODE_RUN;
        default:       mode_d = MODE_RUN;
      endcase
    end
  end

  // Mode decode for the datapath and the registered mode output
  always_comb begin
    run_mode = 1'b0;
    sel_sec  = 1'b0;
    sel_min  = 1'b0;
    sel_hour = 1'b0;
    case (mode_q)
      MODE_RUN:      run_mode = 1'b1;
      MODE_SET_SEC:  sel_sec  = 1'b1;
      MODE_SET_MIN:  sel_min  = 1'b1;
      MODE_SET_HOUR: sel_hour = 1'b1;
      default:       run_mode = 1'b1;
    endcase
  end

  assign o_mode = mode_q;

  // The current mode governs the cycle of a mode step; a mode step swallows
  // any plus event in the same cycle.
  assign count_en  = run_mode & i_one_sec_tick & i_run_en;
  assign plus_inc  = ~run_mode & ~mode_rise & (plus_rise | (plus_held & i_btn_tick));
  assign sec_last  = (sec_q == SEC_LAST);
  assign min_last  = (min_q == SEC_LAST);
  assign hour_last = (hour_q == HOUR_LAST);

  // Time fields: carry chain in RUN, independent wrapping increments in SET
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_q      <= 6'd0;
      min_q      <= 6'd0;
      hour_q     <= 5'd0;
      day_tick_q <= 1'b0;
    end else begin
      day_tick_q <= 1'b0;
      if (count_en) begin
        if (!sec_last) begin
          sec_q <= sec_q + 6'd1;
        end else begin
          sec_q <= 6'd0;
          if (!min_last) begin
            min_q <= min_q + 6'd1;
          end else begin
            min_q <= 6'd0;
            if (!hour_last) begin
              hour_q <= hour_q + 5'd1;
            end else begin
              hour_q     <= 5'd0;
              day_tick_q <= 1'b1;
            end
          end
        end
      end else if (plus_inc) begin
        if (sel_sec) begin
          sec_q <= sec_last ? 6'd0 : sec_q + 6'd1;
        end
        if (sel_min) begin
          min_q <= min_last ? 6'd0 : min_q + 6'd1;
        end
        if (sel_hour) begin
          hour_q <= hour_last ? 5'd0 : hour_q + 5'd1;
        end
      end
    end
  end

  assign o_sec      = sec_q;
  assign o_min      = min_q;
  assign o_hour     = hour_q;
  assign o_day_tick = day_tick_q;

endmodule

// File: tb/tb_matbi_watch_time_counter.sv
// tb/tb_matbi_watch_time_counter.sv - directed self-checking bench for matbi_watch_time_counter
module tb_matbi_watch_time_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_run_en;
  logic       i_one_sec_tick;
  logic       i_btn_tick;
  logic       i_btn_mode;
  logic       i_btn_plus;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic [1:0] o_mode;
  logic       o_day_tick;

  int n_checks = 0;
  int n_fail   = 0;

  matbi_watch_time_counter #(
    .P_HOUR_MAX(24),
    .P_SEC_MAX (60)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_run_en      (i_run_en),
    .i_one_sec_tick(i_one_sec_tick),
    .i_btn_tick    (i_btn_tick),
    .i_btn_mode    (i_btn_mode),
    .i_btn_plus    (i_btn_plus),
    .o_sec         (o_sec),
    .o_min         (o_min),
    .o_hour        (o_hour),
    .o_mode        (o_mode),
    .o_day_tick    (o_day_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    i_btn_mode = 1'b1;
    wait_cyc(3);
    i_btn_mode = 1'b0;
    wait_cyc(3);
  endtask

  task automatic press_plus(input int n);
    repeat (n) begin
      i_btn_plus = 1'b1;
      wait_cyc(3);
      i_btn_plus = 1'b0;
      wait_cyc(3);
    end
  endtask

  task automatic sec_tick();
    i_one_sec_tick = 1'b1;
    wait_cyc(1);
    i_one_sec_tick = 1'b0;
    wait_cyc(1);
  endtask

  task automatic btn_tick();
    i_btn_tick = 1'b1;
    wait_cyc(1);
    i_btn_tick = 1'b0;
    wait_cyc(2);
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check(tag, {15'd0, o_hour, o_min, o_sec}, {15'd0, 5'(h), 6'(m), 6'(s)});
  endtask

  // Field range invariant, checked every cycle out of reset
  always @(negedge clk) begin
    if (reset) begin
      check("range", 32'((o_sec < 6'd60) && (o_min < 6'd60) && (o_hour < 5'd24)), 32'd1);
    end
  end

  initial begin
    reset          = 1'b0;
    i_run_en       = 1'b1;
    i_one_sec_tick = 1'b0;
    i_btn_tick     = 1'b0;
    i_btn_mode     = 1'b0;
    i_btn_plus     = 1'b0;

    // Reset and idle
    wait_cyc(5);
    check_time("rst_time", 0, 0, 0);
    check("rst_mode", 32'(o_mode), 32'd0);
    check("rst_day", 32'(o_day_tick), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_cyc(1);
      check("idle", {19'd0, o_hour, o_min, o_mode, o_day_tick}, 32'd0);
    end

    // Two mode presses -> SET_MIN; plus latency and minute wrap
    press_mode();
    press_mode();
    check("mode_set_min", 32'(o_mode), 32'd2);
    i_btn_plus = 1'b1;
    wait_cyc(1);
    check("lat_edge1", 32'(o_min), 32'd0);
    wait_cyc(1);
    check("lat_edge2", 32'(o_min), 32'd0);
    wait_cyc(1);
    check("lat_edge3", 32'(o_min), 32'd1);
    i_btn_plus = 1'b0;
    wait_cyc(3);
    press_plus(59);
    check_time("min_wrap", 0, 0, 0);

    // SET_HOUR: held plus with 30 auto-repeat ticks, second ticks ignored
    press_mode();
    check("mode_set_hour", 32'(o_mode), 32'd3);
    i_btn_plus = 1'b1;
    wait_cyc(4);
    check("hour_edge", 32'(o_hour), 32'd1);
    for (int i = 0; i < 30; i++) begin
      i_one_sec_tick = 1'b1;
      btn_tick();
      i_one_sec_tick = 1'b0;
    end
    i_btn_plus = 1'b0;
    wait_cyc(3);
    check_time("hour_repeat", 7, 0, 0);
    check("set_no_day", 32'(o_day_tick), 32'd0);

    // Back to RUN, then preload 23:59:58
    press_mode();
    check("mode_run", 32'(o_mode), 32'd0);
    press_mode();
    press_plus(58);
    check_time("preload_sec", 7, 0, 58);

    // Mode and plus rise together in SET_SEC: mode wins
    i_btn_mode = 1'b1;
    i_btn_plus = 1'b1;
    wait_cyc(3);
    check("simul_mode", 32'(o_mode), 32'd2);
    check_time("simul_time", 7, 0, 58);
    i_btn_mode = 1'b0;
    i_btn_plus = 1'b0;
    wait_cyc(3);
    check_time("simul_after", 7, 0, 58);

    press_plus(59);
    press_mode();
    press_plus(16);
    check_time("preload", 23, 59, 58);

    // SET_HOUR -> RUN with a second tick in the stepping cycle: no count
    i_btn_mode = 1'b1;
    wait_cyc(2);
    i_one_sec_tick = 1'b1;
    wait_cyc(1);
    i_one_sec_tick = 1'b0;
    check("step_run_mode", 32'(o_mode), 32'd0);
    check_time("step_run_time", 23, 59, 58);
    i_btn_mode = 1'b0;
    wait_cyc(3);

    // Day rollover
    sec_tick();
    check_time("run_59", 23, 59, 59);
    check("day_early", 32'(o_day_tick), 32'd0);
    i_one_sec_tick = 1'b1;
    wait_cyc(1);
    i_one_sec_tick = 1'b0;
    check_time("rollover", 0, 0, 0);
    check("day_pulse", 32'(o_day_tick), 32'd1);
    wait_cyc(1);
    check("day_clear", 32'(o_day_tick), 32'd0);

    // run_en low drops ticks
    i_run_en = 1'b0;
    repeat (10) sec_tick();
    check_time("run_dis", 0, 0, 0);
    i_run_en = 1'b1;
    sec_tick();
    check_time("run_resume", 0, 0, 1);

    // Set 00:12:34 and return to RUN
    press_mode();
    press_plus(33);
    press_mode();
    press_plus(12);
    press_mode();
    press_mode();
    check("mode_run2", 32'(o_mode), 32'd0);
    check_time("preload2", 0, 12, 34);

    // Reset mid-operation with plus held
    i_btn_plus = 1'b1;
    wait_cyc(4);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_time("rst_async_time", 0, 0, 0);
    check("rst_async_mode", 32'(o_mode), 32'd0);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(6);
    press_mode();
    check("rst_set_sec", 32'(o_mode), 32'd1);
    repeat (3) btn_tick();
    check("held_no_inc", 32'(o_sec), 32'd0);
    i_btn_plus = 1'b0;
    wait_cyc(3);
    check("release_no_inc", 32'(o_sec), 32'd0);
    press_plus(1);
    check("repress_inc", 32'(o_sec), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
